// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Memory stage that sits directly after execute. It accepts one instruction
// at a time. For each instruction it does one of three things:
//   - passes the ALU result straight through (non-memory ops),
//   - issues one data-memory transaction (req/gnt/rvalid) for a load or store,
//   - reports an error for illegal accesses (both enables set, or a
//     misaligned access).
// One result per instruction goes to write-back over a valid/ready handshake.
//
// States: IDLE -> (REQ -> [WAIT_R] ->) DONE -> IDLE
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   valid_i / ready_o     execute-side handshake (ready_o only in IDLE)
//   alu_op_i              operation code, decoded against the OP_* params
//   rmem_ena_i/wmem_ena_i load / store enables
//   alu_result_i          pass-through result for non-memory ops
//   rmem_addr_i           load byte address
//   wmem_addr_i           store byte address
//   wmem_mask_i           store byte mask (bits [3:0] used)
//   wdata_i               right-aligned store data
//   read_offset_i         load byte offset (bits [1:0] used)
//   mem_req_o ... mem_wmask_o   memory request side
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i   memory response side
//   valid_o / ready_i     write-back handshake
//   wb_data_o, err_o      write-back result and fault flag
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, a watchdog aborts a transaction that makes no progress for
//   TIMEOUT_CYCLES cycles in REQ or WAIT_R. The unit then returns err=1 and
//   wb_data=0. When the macro is undefined, the unit waits indefinitely.
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int OP_W           = 8,
  parameter int TIMEOUT_CYCLES = 64,
  // Load/store op encodings; override to match the ALU_OP_BUS defines.
  parameter logic [OP_W-1:0] OP_LB  = OP_W'('h10),
  parameter logic [OP_W-1:0] OP_LH  = OP_W'('h11),
  parameter logic [OP_W-1:0] OP_LW  = OP_W'('h12),
  parameter logic [OP_W-1:0] OP_LBU = OP_W'('h13),
  parameter logic [OP_W-1:0] OP_LHU = OP_W'('h14),
  parameter logic [OP_W-1:0] OP_SH  = OP_W'('h16),
  parameter logic [OP_W-1:0] OP_SW  = OP_W'('h17)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [OP_W-1:0]   alu_op_i,
  input  logic              rmem_ena_i,
  input  logic              wmem_ena_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [ADDR_W-1:0] rmem_addr_i,
  input  logic [ADDR_W-1:0] wmem_addr_i,
  input  logic [7:0]        wmem_mask_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] read_offset_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_wmask_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t              state_reg, state_next;
  logic [OP_W-1:0]     op_reg, op_next;
  logic [1:0]          roff_reg, roff_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [3:0]          wmask_reg, wmask_next;
  logic [DATA_W-1:0]   wb_data_reg, wb_data_next;
  logic                err_reg, err_next;

  logic                timeout_hit;
  logic [1:0]          ld_off, st_off;
  logic                ld_misaligned, st_misaligned;
  logic [DATA_W-1:0]   store_lane;
  logic [DATA_W-1:0]   ld_ext;

  // Select the addressed byte/half of the returned word and extend it.
  // Unknown load ops fall back to the full word.
  function automatic logic [DATA_W-1:0] load_extend(
    input logic [OP_W-1:0]   op,
    input logic [1:0]        off,
    input logic [DATA_W-1:0] word
  );
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] res;
    lane = word >> {off, 3'b000};
    res  = word;
    if (op == OP_LB)       res = {{(DATA_W-8){lane[7]}}, lane[7:0]};
    else if (op == OP_LBU) res = {{(DATA_W-8){1'b0}}, lane[7:0]};
    else if (op == OP_LH)  res = {{(DATA_W-16){lane[15]}}, lane[15:0]};
    else if (op == OP_LHU) res = {{(DATA_W-16){1'b0}}, lane[15:0]};
    return res;
  endfunction

  assign ld_off     = read_offset_i[1:0];
  assign st_off     = wmem_addr_i[1:0];
  assign store_lane = wdata_i << {st_off, 3'b000};
  assign ld_ext     = load_extend(op_reg, roff_reg, mem_rdata_i);

  // A halfword may start at any offset except 3 (it would cross the word).
  // A word must be aligned. A store with no enabled bytes is also rejected.
  assign ld_misaligned = ((alu_op_i == OP_LH || alu_op_i == OP_LHU) && ld_off == 2'd3) ||
                         (alu_op_i == OP_LW && ld_off != 2'd0);
  assign st_misaligned = (alu_op_i == OP_SH && st_off == 2'd3) ||
                         (alu_op_i == OP_SW && st_off != 2'd0) ||
                         (wmem_mask_i[3:0] == 4'd0);

  // Next-state and datapath-capture logic.
  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    roff_next    = roff_reg;
    we_next      = we_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    wmask_next   = wmask_reg;
    wb_data_next = wb_data_reg;
    err_next     = err_reg;

    case (state_reg)
      IDLE: begin
        if (valid_i) begin
          op_next      = alu_op_i;
          roff_next    = ld_off;
          err_next     = 1'b0;
          wb_data_next = alu_result_i;
          if (rmem_ena_i && !wmem_ena_i && !ld_misaligned) begin
            we_next    = 1'b0;
            addr_next  = {rmem_addr_i[ADDR_W-1:2], 2'b00};
            wdata_next = '0;
            wmask_next = 4'd0;
            state_next = REQ;
          end else if (wmem_ena_i && !rmem_ena_i && !st_misaligned) begin
            we_next    = 1'b1;
            addr_next  = {wmem_addr_i[ADDR_W-1:2], 2'b00};
            wdata_next = store_lane;
            wmask_next = wmem_mask_i[3:0];
            state_next = REQ;
          end else begin
            // Non-memory op, or an access that is illegal and never issued.
            err_next   = rmem_ena_i | wmem_ena_i;
            state_next = DONE;
          end
        end
      end

      REQ: begin
        if (mem_gnt_i) begin
          if (we_reg) begin
            wb_data_next = '0;
            state_next   = DONE;
          end else if (mem_rvalid_i) begin
            wb_data_next = ld_ext;
            state_next   = DONE;
          end else begin
            state_next = WAIT_R;
          end
        end else if (timeout_hit) begin
          err_next     = 1'b1;
          wb_data_next = '0;
          state_next   = DONE;
        end
      end

      WAIT_R: begin
        if (mem_rvalid_i) begin
          wb_data_next = ld_ext;
          state_next   = DONE;
        end else if (timeout_hit) begin
          err_next     = 1'b1;
          wb_data_next = '0;
          state_next   = DONE;
        end
      end

      DONE: begin
        if (ready_i) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      op_reg      <= '0;
      roff_reg    <= 2'd0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wmask_reg   <= 4'd0;
      wb_data_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      roff_reg    <= roff_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      wmask_reg   <= wmask_next;
      wb_data_reg <= wb_data_next;
      err_reg     <= err_next;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;

  assign timeout_hit = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));

  // The count restarts whenever the state changes. This covers entry to REQ
  // and the REQ -> WAIT_R step. It only advances while the unit stalls.
  always_comb begin
    tmo_cnt_next = '0;
    if ((state_reg == REQ || state_reg == WAIT_R) && state_next == state_reg)
      tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_cnt_reg <= '0;
    else      tmo_cnt_reg <= tmo_cnt_next;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Outputs. Request and valid come straight from the state register, so an
  // asynchronous reset drops them immediately.
  assign ready_o     = (state_reg == IDLE) & rst;
  assign mem_req_o   = (state_reg == REQ);
  assign mem_we_o    = mem_req_o & we_reg;
  assign mem_addr_o  = addr_reg;
  assign mem_wdata_o = wdata_reg;
  assign mem_wmask_o = wmask_reg;
  assign valid_o     = (state_reg == DONE);
  assign err_o       = valid_o & err_reg;
  assign wb_data_o   = wb_data_reg;

  // Input bits that carry no information for this unit.
  logic unused_ok;
  assign unused_ok = ^{wmem_mask_i[7:4], read_offset_i[ADDR_W-1:2],
                       rmem_addr_i[1:0], 32'(TIMEOUT_CYCLES)};

endmodule
